// File: rtl/inv_sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inv_sqrt_pkg
// Description : Shared types, constants and helpers for the inverse-sqrt core.
// Revision    : 1.0 - initial release
// ============================================================================
package inv_sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEED = 3'd1,
        SQ   = 3'd2,
        MX   = 3'd3,
        SUB  = 3'd4,
        MY   = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [23:0] FP_ONE_HALF_Q = 24'h60_0000;

    localparam logic [31:0] RES_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] RES_NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] RES_QNAN    = 32'h7FC0_0000;

    localparam int FLAG_INVALID = 1;
    localparam int FLAG_DIVZERO = 0;

    typedef struct packed {
        logic sign;
        logic zero;   // zero or denormal
        logic inf;
        logic nan;
    } fp_class_t;

    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.sign = x[31];
        c.zero = (x[30:23] == 8'h00);
        c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        return c;
    endfunction

    // 1.5 - t for non-negative t, done in Q2.22 fixed point and renormalised.
    // t is clamped just below 1.5 so the difference is always a positive normal.
    function automatic logic [31:0] one_half_minus(input logic [30:0] t);
        logic [7:0]  e;
        logic [7:0]  rsh;
        logic [23:0] m;
        logic [23:0] tq;
        logic [23:0] d;
        logic [22:0] frac;
        logic [4:0]  lead;
        e   = t[30:23];
        m   = {1'b1, t[22:0]};
        rsh = 8'd128 - e;
        if (e == 8'd0)
            tq = '0;
        else if (e >= 8'd128)
            tq = FP_ONE_HALF_Q - 24'd1;
        else if (rsh >= 8'd24)
            tq = '0;
        else
            tq = m >> rsh;
        if (tq >= FP_ONE_HALF_Q)
            tq = FP_ONE_HALF_Q - 24'd1;
        d    = FP_ONE_HALF_Q - tq;
        lead = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (d[i])
                lead = 5'(i);
        end
        frac = 23'(d << (5'd23 - lead));
        return {1'b0, 8'd105 + {3'b000, lead}, frac};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sqrt_pipe_fp32_mul.sv
`default_nettype none
// ============================================================================
// Module      : fp32_mul
// Description : Combinational fp32 multiply, truncating, denormals to +0,
//               overflow saturating to signed infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_mul (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_p
);

    logic [47:0]       w_mant;
    logic [24:0]       w_top;
    logic signed [9:0] w_exp;
    logic [22:0]       w_frac;
    logic              w_sign;

    always_comb begin
        w_sign = i_a[31] ^ i_b[31];
        w_mant = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
        w_top  = 25'(w_mant >> 23);
        w_exp  = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]})
               - 10'sd127 + $signed({9'd0, w_top[24]});
        w_frac = w_top[24] ? w_top[23:1] : w_top[22:0];

        if (i_a[30:23] == 8'h00 || i_b[30:23] == 8'h00)
            o_p = '0;
        else if (i_a[30:23] == 8'hFF || i_b[30:23] == 8'hFF)
            o_p = {w_sign, 8'hFF, 23'd0};
        else if (w_exp >= 10'sd255)
            o_p = {w_sign, 8'hFF, 23'd0};
        else if (w_exp <= 10'sd0)
            o_p = '0;
        else
            o_p = {w_sign, w_exp[7:0], w_frac};
    end

endmodule
`default_nettype wire

// File: rtl/inv_sqrt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inv_sqrt_pipe
// Description : Fast inverse square root: magic seed plus NEWTON_ITERS
//               Newton-Raphson steps on one shared fp32 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sqrt_pipe
    import inv_sqrt_pkg::*;
#(
    parameter int          NEWTON_ITERS = 2,
    parameter logic [31:0] MAGIC        = 32'h5F3759DF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] DataIn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] DataOut,
    output logic [1:0]  out_flags
);

    localparam logic [2:0] c_iters = 3'(NEWTON_ITERS);

    state_t      r_state;
    logic [31:0] r_x;
    logic [31:0] r_xh;
    logic [31:0] r_y;
    logic [31:0] r_prod;
    logic [1:0]  r_iter;
    logic [1:0]  r_flags;
    fp_class_t   r_cls;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_data_out;
    logic [1:0]  r_out_flags;

    logic [31:0] w_mul_a;
    logic [31:0] w_mul_b;
    logic [31:0] w_mul_p;
    logic [31:0] w_xh;
    logic [31:0] w_special_res;
    logic [1:0]  w_special_flags;
    logic [1:0]  w_iter_next;
    logic        w_special;

    // Operand routing: SQ = y*y, MX = xh*p, MY = y*r.
    assign w_mul_a     = (r_state == MX) ? r_xh : r_y;
    assign w_mul_b     = (r_state == SQ) ? r_y  : r_prod;
    assign w_iter_next = r_iter + 2'd1;
    assign w_xh        = (DataIn[30:23] <= 8'd1) ? 32'd0
                       : {DataIn[31], DataIn[30:23] - 8'd1, DataIn[22:0]};
    assign w_special   = r_cls.nan | r_cls.zero | r_cls.sign | r_cls.inf;

    fp32_mul u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_mul_p)
    );

    always_comb begin
        w_special_res   = '0;
        w_special_flags = '0;
        if (r_cls.nan) begin
            w_special_res                 = RES_QNAN;
            w_special_flags[FLAG_INVALID] = 1'b1;
        end else if (r_cls.zero) begin
            w_special_res                 = r_cls.sign ? RES_NEG_INF : RES_POS_INF;
            w_special_flags[FLAG_DIVZERO] = 1'b1;
        end else if (r_cls.sign) begin
            w_special_res                 = RES_QNAN;
            w_special_flags[FLAG_INVALID] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_xh        <= '0;
            r_y         <= '0;
            r_prod      <= '0;
            r_iter      <= '0;
            r_flags     <= '0;
            r_cls       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= DataIn;
                        r_xh       <= w_xh;
                        r_cls      <= classify(DataIn);
                        r_iter     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SEED;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                SEED: begin
                    if (w_special) begin
                        r_y     <= w_special_res;
                        r_flags <= w_special_flags;
                        r_state <= DONE;
                    end else begin
                        r_y     <= MAGIC - (r_x >> 1);
                        r_flags <= '0;
                        r_state <= (c_iters == 3'd0) ? DONE : SQ;
                    end
                end
                SQ: begin
                    r_prod  <= w_mul_p;
                    r_state <= MX;
                end
                MX: begin
                    r_prod  <= w_mul_p;
                    r_state <= SUB;
                end
                SUB: begin
                    r_prod  <= one_half_minus(r_prod[30:0]);
                    r_state <= MY;
                end
                MY: begin
                    r_y     <= w_mul_p;
                    r_iter  <= w_iter_next;
                    r_state <= ({1'b0, w_iter_next} < c_iters) ? SQ : DONE;
                end
                DONE: begin
                    // Outputs load once on entry, then hold until the handshake.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_data_out  <= r_y;
                        r_out_flags <= r_flags;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign DataOut   = r_data_out;
    assign out_flags = r_out_flags;

endmodule
`default_nettype wire

// File: tb/tb_inv_sqrt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_sqrt_pipe
// Description : Self-checking bench for inv_sqrt_pipe with 0, 1 and 2 steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sqrt_pipe;

    typedef struct {
        int          dut;
        logic [31:0] x;
        logic [31:0] want;
        logic [1:0]  flags;
        int          lat;
        real         tol;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [2:0]        in_valid;
    logic [2:0]        in_ready;
    logic [2:0][31:0]  data_in;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [2:0][31:0]  data_out;
    logic [2:0][1:0]   out_flags;

    int          checks;
    int          failures;
    vec_t        vecs [12];
    logic [31:0] exp_q [$];

    inv_sqrt_pipe #(.NEWTON_ITERS(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .DataIn(data_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .DataOut(data_out[0]), .out_flags(out_flags[0])
    );
    inv_sqrt_pipe #(.NEWTON_ITERS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .DataIn(data_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .DataOut(data_out[1]), .out_flags(out_flags[1])
    );
    inv_sqrt_pipe #(.NEWTON_ITERS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .DataIn(data_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .DataOut(data_out[2]), .out_flags(out_flags[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real fp2real(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0)   return 0.0;
        if (e == 255) return 1.0e300;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        while (e > 127) begin v = v * 2.0; e--; end
        while (e < 127) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input real want, input real tol);
        real a;
        real err;
        checks++;
        a   = fp2real(act);
        err = (a - want) / want;
        if (err < 0.0) err = -err;
        if (!(err <= tol)) begin
            failures++;
            $display("FAIL %s: got %h (%g) expected %g within rel %g", name, act, a, want, tol);
        end
    endtask

    // One full transaction on DUT d; lat counts edges after the accept edge.
    task automatic run_op(input int d, input logic [31:0] x,
                          output logic [31:0] y, output logic [1:0] f, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[d] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid[d] = 1'b1;
        data_in[d]  = x;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        y = data_out[d];
        f = out_flags[d];
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] y;
        logic [1:0]  f;
        logic [31:0] d0;
        int          lat;
        int          bad;
        checks    = 0;
        failures  = 0;
        in_valid  = '0;
        out_ready = '0;
        data_in   = '0;
        rst       = 1'b1;

        vecs[0]  = '{0, 32'h3F800000, 32'h3F7759DF, 2'b00, 2,  0.0};
        vecs[1]  = '{0, 32'h40800000, 32'h3EF759DF, 2'b00, 2,  0.0};
        vecs[2]  = '{2, 32'h40800000, 32'h3F000000, 2'b00, 10, 1.0e-5};
        vecs[3]  = '{1, 32'h40000000, 32'h3F3504F3, 2'b00, 6,  2.0e-3};
        vecs[4]  = '{2, 32'h00000000, 32'h7F800000, 2'b01, 2,  0.0};
        vecs[5]  = '{2, 32'h80000000, 32'hFF800000, 2'b01, 2,  0.0};
        vecs[6]  = '{2, 32'hBF800000, 32'h7FC00000, 2'b10, 2,  0.0};
        vecs[7]  = '{2, 32'h7FC00001, 32'h7FC00000, 2'b10, 2,  0.0};
        vecs[8]  = '{2, 32'h7F800000, 32'h00000000, 2'b00, 2,  0.0};
        vecs[9]  = '{2, 32'hFF800000, 32'h7FC00000, 2'b10, 2,  0.0};
        vecs[10] = '{2, 32'h00000001, 32'h7F800000, 2'b01, 2,  0.0};
        vecs[11] = '{2, 32'h80400000, 32'hFF800000, 2'b01, 2,  0.0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),     32'd0);
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_data_out",  data_out[2],       32'd0);
        chk("rst_out_flags", 32'(out_flags[2]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h7);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dut, vecs[i].x, y, f, lat);
            if (vecs[i].tol == 0.0)
                chk($sformatf("vec%0d_data", i), y, vecs[i].want);
            else
                chk_near($sformatf("vec%0d_data", i), y, fp2real(vecs[i].want), vecs[i].tol);
            chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Back-pressure: result held for 20 cycles with out_ready low.
        @(posedge clk); #1;
        in_valid[2] = 1'b1;
        data_in[2]  = 32'h40800000;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        lat = 0;
        while (!out_valid[2] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        d0  = data_out[2];
        chk_near("bp_data", d0, 0.5, 1.0e-5);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (data_out[2] !== d0 || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1)
                bad++;
        end
        chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        out_ready[2] = 1'b0;
        chk("bp_in_ready_after", 32'(in_ready[2]), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid[2]), 32'd0);

        // Reset while in MX: accept edge -> SEED -> SQ -> MX.
        in_valid[2] = 1'b1;
        data_in[2]  = 32'h40800000;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid[2]), 32'd0);
        chk("midrst_data_out",  data_out[2],       32'd0);
        chk("midrst_in_ready",  32'(in_ready),     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(2, 32'h40800000, y, f, lat);
        chk_near("midrst_rerun_data", y, 0.5, 1.0e-5);
        chk("midrst_rerun_latency", 32'(lat), 32'd10);

        // Random stream with gaps on both sides.
        exp_q.delete();
        fork
            begin
                logic [31:0] x;
                logic        w;
                int          gap;
                int          g;
                for (int n = 0; n < 100; n++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin @(posedge clk); #1; end
                    x = {1'b0, 8'($urandom_range(64, 190)), 23'($urandom)};
                    in_valid[2] = 1'b1;
                    data_in[2]  = x;
                    g = 0;
                    do begin
                        w = in_ready[2];
                        @(posedge clk); #1;
                        g++;
                    end while (!w && g < 300);
                    in_valid[2] = 1'b0;
                    chk("stream_accept", 32'(w), 32'd1);
                    if (w) exp_q.push_back(x);
                end
            end
            begin
                logic [31:0] xe;
                int          got;
                int          cyc;
                got = 0;
                cyc = 0;
                while (got < 100 && cyc < 20000) begin
                    out_ready[2] = ($urandom_range(0, 3) != 0);
                    if (out_valid[2] && out_ready[2]) begin
                        if (exp_q.size() == 0) begin
                            chk("stream_unexpected", data_out[2], 32'hxxxxxxxx);
                        end else begin
                            xe = exp_q.pop_front();
                            chk_near($sformatf("stream%0d_data", got), data_out[2],
                                     1.0 / $sqrt(fp2real(xe)), 2.0e-5);
                            chk($sformatf("stream%0d_flags", got), 32'(out_flags[2]), 32'd0);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready[2] = 1'b0;
                chk("stream_count", 32'(got), 32'd100);
            end
        join
        chk("stream_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
